// File: rtl/semiauto_turn_executor.sv
// Registered execution stage for the semi-auto driving mode: latches upstream next-state/motion,
// times turns (doubled for U-turns) and drives the direction lights from the registered motion.
module semiauto_turn_executor #(
    parameter int unsigned TICK_DIV   = 2_000_000,
    parameter int unsigned TURN_TICKS = 200
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power,
    input  logic [1:0] global_state,
    input  logic [1:0] next_state,
    input  logic [3:0] next_moving_state,
    input  logic       back,
    output logic [1:0] state,
    output logic [3:0] moving_state,
    output logic       turn_done,
    output logic       move_forward_light,
    output logic       move_backward_light,
    output logic       turn_left_light,
    output logic       turn_right_light
);

    localparam int unsigned TickW = $clog2(TICK_DIV);

    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam logic [10:0]      LimNorm  = 11'(TURN_TICKS - 1);
    localparam logic [10:0]      LimUturn = 11'(2 * TURN_TICKS - 1);

    localparam logic [3:0] MvStop    = 4'b0000;
    localparam logic [3:0] MvForward = 4'b0001;
    localparam logic [3:0] MvLeft    = 4'b0100;
    localparam logic [3:0] MvRight   = 4'b1000;

    typedef enum logic [1:0] {
        StForward  = 2'b00,
        StWaiting  = 2'b01,
        StTurning  = 2'b10,
        StCooldown = 2'b11
    } st_e;

    st_e              state_q, state_d;
    logic [3:0]       moving_q, moving_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [10:0]      turn_q, turn_d;
    logic             around_q, around_d;
    logic             done_q, done_d;
    logic             fwd_q, fwd_d;
    logic             bwd_q, bwd_d;
    logic             left_q, left_d;
    logic             right_q, right_d;

    logic       active;
    logic       tick_wrap;
    logic       turn_last;
    logic [3:0] moving_clean;

    assign active    = power && (global_state == 2'b01 || global_state == 2'b10);
    assign tick_wrap = (tick_q == TickLast);
    assign turn_last = (turn_q == (around_q ? LimUturn : LimNorm));

    // Anything other than the four legal motion codes is treated as a stop request.
    always_comb begin
        moving_clean = MvStop;
        case (next_moving_state)
            MvForward, MvLeft, MvRight: moving_clean = next_moving_state;
            default:                    moving_clean = MvStop;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q  <= StWaiting;
            moving_q <= MvStop;
            tick_q   <= '0;
            turn_q   <= '0;
            around_q <= 1'b0;
            done_q   <= 1'b0;
            fwd_q    <= 1'b0;
            bwd_q    <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            moving_q <= moving_d;
            tick_q   <= tick_d;
            turn_q   <= turn_d;
            around_q <= around_d;
            done_q   <= done_d;
            fwd_q    <= fwd_d;
            bwd_q    <= bwd_d;
            left_q   <= left_d;
            right_q  <= right_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        moving_d = moving_q;
        tick_d   = tick_q;
        turn_d   = turn_q;
        around_d = around_q;
        done_d   = 1'b0;

        if (!active) begin
            state_d  = StWaiting;
            moving_d = MvStop;
            tick_d   = '0;
            turn_d   = '0;
            around_d = 1'b0;
        end else if (state_q == StTurning) begin
            // Upstream holds s3 indefinitely; only the tick counters can end a turn.
            if (tick_wrap && turn_last) begin
                state_d  = StWaiting;
                moving_d = MvStop;
                tick_d   = '0;
                turn_d   = '0;
                around_d = 1'b0;
                done_d   = 1'b1;
            end else if (tick_wrap) begin
                tick_d = '0;
                turn_d = turn_q + 11'd1;
            end else begin
                tick_d = tick_q + TickW'(1);
            end
        end else begin
            state_d  = st_e'(next_state);
            moving_d = moving_clean;
            if (st_e'(next_state) == StTurning) begin
                tick_d   = '0;
                turn_d   = '0;
                around_d = back;
            end
        end

        // Lights follow the motion code being written, so they land on the same edge.
        fwd_d   = (moving_d == MvForward);
        left_d  = (moving_d == MvLeft);
        right_d = (moving_d == MvRight);
        bwd_d   = (moving_d == MvRight) && around_d;
    end

    // Output logic
    always_comb begin
        state               = state_q;
        moving_state        = moving_q;
        turn_done           = done_q;
        move_forward_light  = fwd_q;
        move_backward_light = bwd_q;
        turn_left_light     = left_q;
        turn_right_light    = right_q;
    end

endmodule

// File: tb/tb_semiauto_turn_executor.sv
// Directed bench for semiauto_turn_executor with TICK_DIV=4, TURN_TICKS=3 (12-cycle turns).
module tb_semiauto_turn_executor;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       power;
    logic [1:0] global_state;
    logic [1:0] next_state;
    logic [3:0] next_moving_state;
    logic       back;
    logic [1:0] state;
    logic [3:0] moving_state;
    logic       turn_done;
    logic       move_forward_light;
    logic       move_backward_light;
    logic       turn_left_light;
    logic       turn_right_light;

    int n_cmp  = 0;
    int n_fail = 0;

    semiauto_turn_executor #(
        .TICK_DIV  (4),
        .TURN_TICKS(3)
    ) dut (
        .sys_clk            (sys_clk),
        .rst                (rst),
        .power              (power),
        .global_state       (global_state),
        .next_state         (next_state),
        .next_moving_state  (next_moving_state),
        .back               (back),
        .state              (state),
        .moving_state       (moving_state),
        .turn_done          (turn_done),
        .move_forward_light (move_forward_light),
        .move_backward_light(move_backward_light),
        .turn_left_light    (turn_left_light),
        .turn_right_light   (turn_right_light)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic       power;
        logic [1:0] gs;
        logic [1:0] ns;
        logic [3:0] nms;
        logic [1:0] exp_state;
        logic [3:0] exp_ms;
        logic [3:0] exp_lights;  // {fwd, bwd, left, right}
    } vec_t;

    vec_t vecs[9];

    function automatic logic [3:0] lights();
        return {move_forward_light, move_backward_light, turn_left_light, turn_right_light};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Called just after the entry edge; counts cycles spent in s3 and checks the completion edge.
    task automatic measure_turn(input string name, input int exp_len, input logic [3:0] exp_l,
                                input logic drop_back);
        int len = 0;
        int bad = 0;
        while (state == 2'b10 && len < 200) begin
            if (lights() !== exp_l || turn_done !== 1'b0 || moving_state === 4'b0000) bad++;
            len++;
            if (drop_back && len == 2) back = 1'b0;
            step();
        end
        chk({name, "_len"}, len, exp_len);
        chk({name, "_inturn"}, bad, 0);
        chk({name, "_end_state"}, state, 2'b01);
        chk({name, "_end_ms"}, moving_state, 4'b0000);
        chk({name, "_end_lights"}, lights(), 4'b0000);
        chk({name, "_done_rise"}, turn_done, 1'b1);
        // Still requesting s3 here: completion must have won, and the pulse must drop now.
        next_state        = 2'b01;
        next_moving_state = 4'b0000;
        step();
        chk({name, "_done_fall"}, turn_done, 1'b0);
        chk({name, "_after_state"}, state, 2'b01);
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'b01, 2'b00, 4'b0001, 2'b00, 4'b0001, 4'b1000};
        vecs[1] = '{1'b1, 2'b10, 2'b01, 4'b0100, 2'b01, 4'b0100, 4'b0010};
        vecs[2] = '{1'b1, 2'b01, 2'b11, 4'b1000, 2'b11, 4'b1000, 4'b0001};
        vecs[3] = '{1'b1, 2'b01, 2'b00, 4'b0110, 2'b00, 4'b0000, 4'b0000};
        vecs[4] = '{1'b1, 2'b10, 2'b00, 4'b1111, 2'b00, 4'b0000, 4'b0000};
        vecs[5] = '{1'b0, 2'b01, 2'b00, 4'b0001, 2'b01, 4'b0000, 4'b0000};
        vecs[6] = '{1'b1, 2'b00, 2'b00, 4'b0001, 2'b01, 4'b0000, 4'b0000};
        vecs[7] = '{1'b1, 2'b11, 2'b11, 4'b0100, 2'b01, 4'b0000, 4'b0000};
        vecs[8] = '{1'b1, 2'b01, 2'b01, 4'b0000, 2'b01, 4'b0000, 4'b0000};

        rst               = 1'b1;
        power             = 1'b0;
        global_state      = 2'b00;
        next_state        = 2'b00;
        next_moving_state = 4'b0000;
        back              = 1'b0;
        step();
        step();
        chk("reset_state", state, 2'b01);
        chk("reset_ms", moving_state, 4'b0000);
        chk("reset_done", turn_done, 1'b0);
        chk("reset_lights", lights(), 4'b0000);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            power             = vecs[i].power;
            global_state      = vecs[i].gs;
            next_state        = vecs[i].ns;
            next_moving_state = vecs[i].nms;
            step();
            chk($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
            chk($sformatf("vec%0d_ms", i), moving_state, vecs[i].exp_ms);
            chk($sformatf("vec%0d_lights", i), lights(), vecs[i].exp_lights);
            chk($sformatf("vec%0d_done", i), turn_done, 1'b0);
        end

        // Left turn, normal duration.
        power = 1'b1; global_state = 2'b01;
        next_state = 2'b10; next_moving_state = 4'b0100; back = 1'b0;
        step();
        measure_turn("left", 12, 4'b0010, 1'b0);

        // U-turn: back only matters at entry.
        next_state = 2'b10; next_moving_state = 4'b1000; back = 1'b1;
        step();
        measure_turn("uturn", 24, 4'b0101, 1'b1);

        // Abort by dropping power partway into a turn.
        next_state = 2'b10; next_moving_state = 4'b0100; back = 1'b0;
        step();
        for (int i = 0; i < 4; i++) step();
        chk("abort_pre_state", state, 2'b10);
        power = 1'b0;
        step();
        chk("abort_state", state, 2'b01);
        chk("abort_ms", moving_state, 4'b0000);
        chk("abort_lights", lights(), 4'b0000);
        chk("abort_done", turn_done, 1'b0);
        power = 1'b1;
        step();
        measure_turn("return", 12, 4'b0010, 1'b0);

        // Asynchronous reset between clock edges.
        next_state = 2'b10; next_moving_state = 4'b1000; back = 1'b1;
        step();
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_state", state, 2'b01);
        chk("arst_ms", moving_state, 4'b0000);
        chk("arst_lights", lights(), 4'b0000);
        chk("arst_done", turn_done, 1'b0);
        #1 rst = 1'b0;
        next_state = 2'b00; next_moving_state = 4'b0001; back = 1'b0;
        step();
        chk("post_arst_state", state, 2'b00);
        chk("post_arst_lights", lights(), 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/semiauto_turn_executor.md
# semiauto_turn_executor

Registered execution stage directly downstream of the semi-auto next-state logic. Latches `next_state`/`next_moving_state` every `sys_clk` edge into `state`/`moving_state`, which feed back to that logic. Owns turn timing: the upstream logic holds s3 (turning) indefinitely, and this block ends each turn after a fixed duration, or double that duration for a U-turn. Drives the four direction lights from the registered motion code.

## Interface
- `TICK_DIV`, 2_000_000: `sys_clk` cycles per turn tick (20 ms at 100 MHz); legal range ≥ 2.
- `TURN_TICKS`, 200: ticks per normal turn; legal range 1..1023.
- `sys_clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `power` input 1: car powered.
- `global_state` input 2: semi-auto is active when the value is 2'b01 or 2'b10.
- `next_state` input 2: upstream next state (s1=00 forward, s2=01 waiting, s3=10 turning, s4=11 cooldown).
- `next_moving_state` input 4: upstream motion code (STOP=0000, MOVE_FORWARD=0001, TURN_LEFT=0100, TURN_RIGHT=1000).
- `back` input 1: U-turn request, sampled only on turn entry.
- `state` output 2: registered state.
- `moving_state` output 4: registered motion code.
- `turn_done` output 1: one-cycle pulse when a timed turn completes.
- `move_forward_light`, `move_backward_light`, `turn_left_light`, `turn_right_light` output 1 each: registered lights.

## Operation
- Active means `power`=1 and `global_state` is 01 or 10. When not active, every edge sets `state`=s2 and `moving_state`=STOP, clears the counters and `around`, and holds all lights at 0.
- Sanitising: a `next_moving_state` value outside the four legal codes is registered as STOP.
- Pass-through (active, `state`≠s3): `state`<=`next_state`; `moving_state`<=sanitised `next_moving_state`.
- Turn entry is an edge where `state`≠s3 and `next_state`=s3. On that edge: `tick_cnt`<=0, `turn_cnt`<=0, `around`<=`back`.
- Turning (active, `state`=s3): upstream inputs are ignored and `moving_state` is held.
  - `tick_cnt` increments each edge and wraps from TICK_DIV-1 to 0.
  - On each wrap, `turn_cnt` increments (11 bits).
- Limit is L = TURN_TICKS when `around`=0, and L = 2·TURN_TICKS when `around`=1.
- Completion is the edge where `tick_cnt`=TICK_DIV-1 and `turn_cnt`=L-1. On that edge: `state`<=s2, `moving_state`<=STOP, `turn_done`<=1, counters cleared.
- `turn_done` is 0 on every other edge.
- Lights are registered on the same edge as `moving_state` and decoded from the value being written:
  - forward = MOVE_FORWARD;
  - left = TURN_LEFT;
  - right = TURN_RIGHT;
  - backward = TURN_RIGHT with `around`=1 (U-turn indicator), with right also lit.
- Counter widths: `tick_cnt` is ceil(log2(TICK_DIV)) bits; `turn_cnt` is 11 bits (max L = 2046, no overflow).

## Timing
- Reset values: `state`=s2, `moving_state`=0000, `turn_done`=0, all lights 0, counters 0, `around`=0.
- Pass-through latency is one `sys_clk` edge, from input to `state`/`moving_state`/lights.
- A turn holds `state`=s3 for exactly L·TICK_DIV cycles, counted from the entry edge to the completion edge.
- `turn_done` rises on the completion edge and falls on the next edge.
- Deactivation mid-turn takes effect on the next edge. The turn is aborted with no `turn_done` pulse. On reactivation a new turn starts from zero.
- `rst` mid-turn clears everything immediately, without waiting for a clock edge.
- `back` changing during a turn has no effect.
- If `next_state`=s3 on the completion edge, completion wins and `state`=s2. A new turn can only be entered from the following edge, which is at least one cycle in s2.

## Test plan
(Use TICK_DIV=4, TURN_TICKS=3.)
- Reset then activate (`power`=1, `global_state`=01), `next_state`=s1, `next_moving_state`=0001 → after 1 edge `state`=00, `moving_state`=0001, `move_forward_light`=1, all other lights 0.
- Left turn with `back`=0: `next_state`=10, `next_moving_state`=0100, held → `state`=10 for 12 cycles, `turn_left_light`=1; then `state`=01, `moving_state`=0000, `turn_done`=1 for exactly 1 cycle.
- U-turn: `next_moving_state`=1000 with `back`=1 at entry, `back` dropped to 0 after 2 cycles → `state`=10 for 24 cycles, `turn_right_light`=1 and `move_backward_light`=1 throughout, then one `turn_done` pulse.
- Abort: drop `power` at cycle 5 of a turn → next edge `state`=01, `moving_state`=0000, lights 0, no `turn_done`. Re-power with s3 requested → the turn lasts a full 12 cycles.
- Assert `rst` asynchronously mid-turn, between clock edges → outputs go to reset values before the next `sys_clk` edge.
- Illegal code `next_moving_state`=0110 with `next_state`=00 → `moving_state`=0000, all lights 0.
